mult_arb_seq: RTL and testbench
===============================

MULT_ARB_SEQ -- requirements
Module: mult_arb_seq

Interface
REQ-001 SHALL have parameter BITS, default 8, operand width (legal 4..16).
REQ-002 SHALL have port Clk, input, 1, sole clock, rising edge.
REQ-003 SHALL have port Reset_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have ports req0_valid/req1_valid, input, 1, requester has operands.
REQ-005 SHALL have ports req0_ready/req1_ready, output, 1, requester accepted this cycle.
REQ-006 SHALL have ports req0_a, req0_b, req1_a, req1_b, input, BITS each, signed multiplicand (a) and multiplier (b).
REQ-007 SHALL have port rsp_valid, output, 1, product available.
REQ-008 SHALL have port rsp_ready, input, 1, consumer takes product.
REQ-009 SHALL have port rsp_id, output, 1, requester that owns rsp_prod.
REQ-010 SHALL have port rsp_prod, output, 2*BITS, signed product.
REQ-011 SHALL have ports add_en, sub_en, shift_en, output, 1 each, datapath strobes.
REQ-012 SHALL have port busy, output, 1, high in any state other than IDLE.
REQ-013 SHALL have ports cnt0, cnt1, output, 16 each, completion counters.

Function
REQ-014 SHALL implement FSM states IDLE, LOAD, ADD, SUB, SHIFT, DONE.
REQ-015 SHALL assert req_ready only in IDLE, to at most one requester, and only to one whose valid is high.
REQ-016 SHALL arbitrate round-robin: if both valid, grant the requester not served last; after reset req0 wins a tie.
REQ-017 SHALL, on accept (valid&ready), capture a, b and id, and go IDLE->LOAD.
REQ-018 SHALL, in LOAD, clear accumulator A and sign bit X, load B, clear bit counter; LOAD->ADD if B[0]=1, else SHIFT.
REQ-019 SHALL, in ADD, set A = A + a in BITS+1 bits, with X taking the sign; ADD->SHIFT.
REQ-020 SHALL, for the final bit (counter = BITS-1) with M=1, enter SUB instead of ADD, set A = A - a, then go SUB->SHIFT.
REQ-021 SHALL, in SHIFT, shift {X,A,B} right arithmetically by one and increment the counter; go to DONE after the BITS-th shift, else to ADD/SUB/SHIFT per the new B[0].
REQ-022 SHALL make rsp_valid rise exactly 1+BITS+popcount(b) cycles after the accept edge.
REQ-023 SHALL hold rsp_valid, rsp_prod={A,B} and rsp_id stable in DONE until rsp_ready; DONE->IDLE on rsp_valid&rsp_ready; no accept in that cycle.
REQ-024 SHALL assert exactly one of add_en/sub_en/shift_en in ADD/SUB/SHIFT respectively, and none elsewhere.
REQ-025 SHALL ignore requester inputs while busy; a requester's valid with no ready SHALL NOT be lost, only delayed.
REQ-026 SHALL produce exact two's-complement products, including -2^(BITS-1) * -2^(BITS-1).

Reset
REQ-027 SHALL, while Reset_n=0, force IDLE, all ready/valid/strobes/busy 0, rsp_prod 0, rsp_id 0, counters 0, and RR pointer "last served = req1"; this applies immediately and mid-operation, and any in-flight product SHALL be discarded.

Configuration
REQ-028 SHALL, with MULT_ARB_STATS_EN defined, increment cnt0/cnt1 (wrapping 0xFFFF->0) on each response handshake for rsp_id 0/1.
REQ-029 SHALL, without MULT_ARB_STATS_EN, keep ports cnt0/cnt1 present and tied to 0, with no counter flops.

Structure
REQ-030 SHALL place the state enum, default BITS and the requester-id type in package mult_pkg.
REQ-031 SHALL contain one sub-module, mult_datapath, holding A, B, X, the BITS+1 adder/subtractor and the shifter, driven by the strobes.

Verification
REQ-032 SHALL cover: req0 a=0x07 b=0x03 -> rsp_prod 0x0015, rsp_id 0, rsp_valid 11 cycles after accept.
REQ-033 SHALL cover: req1 a=0xF9 b=0x03 -> 0xFFEB; a=0x07 b=0xFD -> 0xFFEB, latency 16; a=0x80 b=0x80 -> 0x4000, latency 10.
REQ-034 SHALL cover: both valid continuously from reset, rsp_ready=1 -> grants alternate 0,1,0,1; rsp_id matches each grant.
REQ-035 SHALL cover: rsp_ready low 5 cycles in DONE -> rsp_valid/rsp_prod stable, both ready low; release -> IDLE next cycle.
REQ-036 SHALL cover: Reset_n low during SHIFT -> all outputs 0 asynchronously, no response after release, next request served normally.
REQ-037 SHALL cover: with MULT_ARB_STATS_EN, 3 req0 and 2 req1 completions -> cnt0=3, cnt1=2; without the macro -> both 0.

Source files
------------

// File: rtl/mult_pkg.sv
// Shared types and defaults for the arbitrated sequential multiplier.
//   DefaultBits : default operand width
//   req_id_t    : requester identifier (0 = req0, 1 = req1)
//   state_e     : control FSM states
package mult_pkg;

  localparam int unsigned DefaultBits = 8;

  typedef logic req_id_t;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StAdd,
    StSub,
    StShift,
    StDone
  } state_e;

endpackage

// File: rtl/mult_datapath.sv
// Shift-add datapath for a signed (two's-complement) sequential multiplier.
// Holds the accumulator A, its extension/sign bit X and the multiplier
// register B. The strobes from the controller select the operation:
//   load_en  : A <= 0, X <= 0, B <= mplier
//   add_en   : {X,A} <= {X,A} + sext(mcand)   (BITS+1 bits)
//   sub_en   : {X,A} <= {X,A} - sext(mcand)   (BITS+1 bits)
//   shift_en : {X,A,B} <= {X,A,B} >>> 1
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   mcand        : multiplicand (signed)
//   mplier       : multiplier (signed), loaded into B
//   b_next_lsb   : B[1], i.e. the bit that becomes B[0] after the next shift
//   prod         : {A,B}, the signed product once all bits are consumed
module mult_datapath
  import mult_pkg::*;
#(
  parameter int unsigned BITS = DefaultBits
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_en,
  input  logic              add_en,
  input  logic              sub_en,
  input  logic              shift_en,
  input  logic [BITS-1:0]   mcand,
  input  logic [BITS-1:0]   mplier,
  output logic              b_next_lsb,
  output logic [2*BITS-1:0] prod
);

  logic            x_q, x_d;
  logic [BITS-1:0] a_q, a_d;
  logic [BITS-1:0] b_q, b_d;
  logic [BITS:0]   acc;
  logic [BITS:0]   opnd;
  logic [BITS:0]   sum;

  always_comb begin
    // Outside ADD/SUB, X always equals A's MSB, so {X,A} is the
    // sign-extended partial product and BITS+1 bits cannot overflow.
    acc  = {x_q, a_q};
    opnd = {mcand[BITS-1], mcand};
    sum  = sub_en ? (acc - opnd) : (acc + opnd);

    x_d = x_q;
    a_d = a_q;
    b_d = b_q;
    if (load_en) begin
      x_d = 1'b0;
      a_d = '0;
      b_d = mplier;
    end else if (add_en || sub_en) begin
      x_d = sum[BITS];
      a_d = sum[BITS-1:0];
    end else if (shift_en) begin
      // Arithmetic shift: X keeps its value and refills A's MSB.
      a_d = {x_q, a_q[BITS-1:1]};
      b_d = {a_q[0], b_q[BITS-1:1]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q <= 1'b0;
      a_q <= '0;
      b_q <= '0;
    end else begin
      x_q <= x_d;
      a_q <= a_d;
      b_q <= b_d;
    end
  end

  assign b_next_lsb = b_q[1];
  assign prod       = {a_q, b_q};

endmodule

// File: rtl/mult_arb_seq.sv
// Two-requester, round-robin arbitrated sequential signed multiplier.
// One product is computed at a time with a shift-add FSM; the last
// multiplier bit (sign bit) is subtracted instead of added so the result is
// an exact two's-complement product.
// Ports:
//   Clk, Reset_n             : clock (rising edge), async active-low reset
//   reqN_valid / reqN_ready  : requester N handshake (ready only in IDLE)
//   reqN_a / reqN_b          : signed multiplicand / multiplier
//   rsp_valid / rsp_ready    : product handshake, held in DONE until taken
//   rsp_id, rsp_prod         : owner of the product, 2*BITS signed product
//   add_en, sub_en, shift_en : datapath strobes (ADD / SUB / SHIFT states)
//   busy                     : high whenever the FSM is not IDLE
//   cnt0, cnt1               : per-requester completion counters
// Build option: define MULT_ARB_STATS_EN to enable the completion counters;
// otherwise cnt0/cnt1 are tied to zero and no counter flops exist.
module mult_arb_seq
  import mult_pkg::*;
#(
  parameter int unsigned BITS = DefaultBits
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [BITS-1:0]   req0_a,
  input  logic [BITS-1:0]   req0_b,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [BITS-1:0]   req1_a,
  input  logic [BITS-1:0]   req1_b,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output req_id_t           rsp_id,
  output logic [2*BITS-1:0] rsp_prod,
  output logic              add_en,
  output logic              sub_en,
  output logic              shift_en,
  output logic              busy,
  output logic [15:0]       cnt0,
  output logic [15:0]       cnt1
);

  localparam int unsigned     CntW    = $clog2(BITS + 1);
  localparam logic [CntW-1:0] LastBit = CntW'(BITS - 1);

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  req_id_t         last_q;
  req_id_t         id_q;
  logic [BITS-1:0] mcand_q;
  logic [BITS-1:0] mplier_q;

  logic idle;
  logic pick1;
  logic grant0;
  logic grant1;
  logic accept;
  logic load_en;
  logic b_next_lsb;
  logic rsp_fire;

  // Arbitration. last_q == 1 means req1 was served last, so req0 wins a tie.
  // Reset_n gates the grants so ready stays low while reset is asserted.
  assign idle   = (state_q == StIdle);
  assign pick1  = req1_valid & (~req0_valid | ~last_q);
  assign grant0 = Reset_n & idle & req0_valid & ~pick1;
  assign grant1 = Reset_n & idle & pick1;
  assign accept = grant0 | grant1;

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  assign rsp_valid = (state_q == StDone);
  assign busy      = ~idle;
  assign rsp_id    = id_q;
  assign rsp_fire  = rsp_valid & rsp_ready;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    load_en  = 1'b0;
    add_en   = 1'b0;
    sub_en   = 1'b0;
    shift_en = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = StLoad;
        end
      end
      StLoad: begin
        load_en = 1'b1;
        cnt_d   = '0;
        // Bit 0 is never the final bit (BITS >= 4), so it is always added.
        state_d = mplier_q[0] ? StAdd : StShift;
      end
      StAdd: begin
        add_en  = 1'b1;
        state_d = StShift;
      end
      StSub: begin
        sub_en  = 1'b1;
        state_d = StShift;
      end
      StShift: begin
        shift_en = 1'b1;
        cnt_d    = cnt_q + CntW'(1);
        if (cnt_q == LastBit) begin
          state_d = StDone;
        end else if (b_next_lsb) begin
          // The next bit processed is the sign bit: it carries weight -2^(BITS-1).
          state_d = (cnt_q == (LastBit - CntW'(1))) ? StSub : StAdd;
        end else begin
          state_d = StShift;
        end
      end
      StDone: begin
        if (rsp_ready) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      last_q   <= 1'b1;
      id_q     <= 1'b0;
      mcand_q  <= '0;
      mplier_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        mcand_q  <= grant1 ? req1_a : req0_a;
        mplier_q <= grant1 ? req1_b : req0_b;
        id_q     <= grant1;
        last_q   <= grant1;
      end
    end
  end

  mult_datapath #(
    .BITS(BITS)
  ) u_datapath (
    .clk       (Clk),
    .rst_n     (Reset_n),
    .load_en   (load_en),
    .add_en    (add_en),
    .sub_en    (sub_en),
    .shift_en  (shift_en),
    .mcand     (mcand_q),
    .mplier    (mplier_q),
    .b_next_lsb(b_next_lsb),
    .prod      (rsp_prod)
  );

`ifdef MULT_ARB_STATS_EN
  logic [15:0] cnt0_q;
  logic [15:0] cnt1_q;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else if (rsp_fire) begin
      if (id_q) begin
        cnt1_q <= cnt1_q + 16'd1;
      end else begin
        cnt0_q <= cnt0_q + 16'd1;
      end
    end
  end

  assign cnt0 = cnt0_q;
  assign cnt1 = cnt1_q;
`else
  logic unused_rsp_fire;
  assign unused_rsp_fire = rsp_fire;
  assign cnt0 = '0;
  assign cnt1 = '0;
`endif

endmodule

// File: tb/tb_mult_arb_seq.sv
// Scoreboard bench for mult_arb_seq: requests are drawn from per-requester
// queues, the expected product/latency is pushed when a grant is observed,
// and an independent monitor pops and compares on each response handshake.
module tb_mult_arb_seq;

  localparam int BITS = 8;
  localparam int PW   = 2 * BITS;

  logic            Clk;
  logic            Reset_n;
  logic            req0_valid, req0_ready, req1_valid, req1_ready;
  logic [BITS-1:0] req0_a, req0_b, req1_a, req1_b;
  logic            rsp_valid, rsp_ready, rsp_id;
  logic [PW-1:0]   rsp_prod;
  logic            add_en, sub_en, shift_en, busy;
  logic [15:0]     cnt0, cnt1;

  mult_arb_seq #(
    .BITS(BITS)
  ) dut (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .req0_valid(req0_valid),
    .req0_ready(req0_ready),
    .req0_a    (req0_a),
    .req0_b    (req0_b),
    .req1_valid(req1_valid),
    .req1_ready(req1_ready),
    .req1_a    (req1_a),
    .req1_b    (req1_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_prod  (rsp_prod),
    .add_en    (add_en),
    .sub_en    (sub_en),
    .shift_en  (shift_en),
    .busy      (busy),
    .cnt0      (cnt0),
    .cnt1      (cnt1)
  );

  typedef struct {
    logic [BITS-1:0] a;
    logic [BITS-1:0] b;
  } op_t;

  typedef struct {
    logic          id;
    logic [PW-1:0] prod;
    int            lat;
    int            acc_cyc;
    logic [BITS-1:0] b;
  } exp_t;

  op_t  q0[$];
  op_t  q1[$];
  exp_t exp_q[$];
  int   grant_log[$];

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  logic last = 1'b1;
  bit   acc0 = 0, acc1 = 0;
  int   rdy_mode = 0;
  int   n_add = 0, n_sub = 0, n_shift = 0;
  bit   prev_valid = 0, hold_pend = 0;
  logic [PW-1:0] held_prod;
  logic          held_id;
  int   m_cnt0 = 0, m_cnt1 = 0;

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  always @(posedge Clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got 0x%0h want 0x%0h (t=%0t)", name, got, want, $time);
    end
  endtask

  // Reference: exact signed product, latency = LOAD + one shift per bit + one
  // add/sub per set multiplier bit.
  function automatic exp_t make_exp(input logic id, input op_t op, input int acc);
    exp_t e;
    int   sa, sb;
    sa        = $signed(op.a);
    sb        = $signed(op.b);
    e.id      = id;
    e.prod    = PW'(sa * sb);
    e.lat     = 1 + BITS + $countones(op.b);
    e.acc_cyc = acc;
    e.b       = op.b;
    return e;
  endfunction

  // One cycle of stimulus: retire last accept, drive inputs, check handshake.
  task automatic step();
    bit   exp_any;
    logic g;
    op_t  op;
    @(negedge Clk);
    if (acc0) begin void'(q0.pop_front()); acc0 = 0; end
    if (acc1) begin void'(q1.pop_front()); acc1 = 0; end
    req0_valid = (q0.size() != 0);
    req0_a     = req0_valid ? q0[0].a : BITS'($urandom);
    req0_b     = req0_valid ? q0[0].b : BITS'($urandom);
    req1_valid = (q1.size() != 0);
    req1_a     = req1_valid ? q1[0].a : BITS'($urandom);
    req1_b     = req1_valid ? q1[0].b : BITS'($urandom);
    case (rdy_mode)
      0:       rsp_ready = 1'b1;
      1:       rsp_ready = ($urandom_range(0, 3) != 0);
      default: rsp_ready = 1'b0;
    endcase
    #1;
    check("busy", busy, exp_q.size() != 0);
    exp_any = Reset_n && (req0_valid || req1_valid) && (exp_q.size() == 0);
    check("ready_any", req0_ready | req1_ready, exp_any);
    if (exp_any) begin
      g = (req0_valid && req1_valid) ? ~last : req1_valid;
      check("grant", {req1_ready, req0_ready}, g ? 2'b10 : 2'b01);
      op = g ? q1[0] : q0[0];
      exp_q.push_back(make_exp(g, op, cyc + 1));
      grant_log.push_back(int'(g));
      last = g;
      if (g) acc1 = 1; else acc0 = 1;
    end
  endtask

  task automatic monitor_sample();
    int   ns;
    exp_t e;
    int   msb;
    ns = int'(add_en) + int'(sub_en) + int'(shift_en);
    if (ns != 0) begin
      check("one_strobe", ns, 1);
      check("strobe_inflight", exp_q.size() != 0, 1);
      n_add   += int'(add_en);
      n_sub   += int'(sub_en);
      n_shift += int'(shift_en);
    end
    if (hold_pend) begin
      check("hold_valid", rsp_valid, 1);
      check("hold_prod", rsp_prod, held_prod);
      check("hold_id", rsp_id, held_id);
    end
    hold_pend = 0;
    if (rsp_valid) begin
      if (exp_q.size() == 0) begin
        check("spurious_rsp", rsp_valid, 0);
      end else begin
        e = exp_q[0];
        if (!prev_valid) check("latency", cyc - e.acc_cyc, e.lat);
        if (rsp_ready) begin
          msb = int'(e.b[BITS-1]);
          check("prod", rsp_prod, e.prod);
          check("id", rsp_id, e.id);
          check("n_shift", n_shift, BITS);
          check("n_sub", n_sub, msb);
          check("n_add", n_add, $countones(e.b) - msb);
          void'(exp_q.pop_front());
          if (e.id) m_cnt1++; else m_cnt0++;
          n_add = 0; n_sub = 0; n_shift = 0;
        end else begin
          hold_pend = 1;
          held_prod = rsp_prod;
          held_id   = rsp_id;
        end
      end
    end
    prev_valid = rsp_valid;
  endtask

  initial begin
    forever begin
      @(negedge Clk);
      #2;
      if (Reset_n) monitor_sample();
    end
  end

  task automatic check_all_zero();
    check("rst_ready0", req0_ready, 0);
    check("rst_ready1", req1_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_prod", rsp_prod, 0);
    check("rst_rsp_id", rsp_id, 0);
    check("rst_strobes", {add_en, sub_en, shift_en}, 0);
    check("rst_busy", busy, 0);
    check("rst_cnt0", cnt0, 0);
    check("rst_cnt1", cnt1, 0);
  endtask

  // Asynchronous assert away from clock edges; model forgets in-flight work.
  task automatic assert_reset();
    #2;
    Reset_n = 1'b0;
    #1;
    check_all_zero();
    exp_q.delete();
    grant_log.delete();
    acc0 = 0; acc1 = 0;
    last = 1'b1;
    prev_valid = 0; hold_pend = 0;
    n_add = 0; n_sub = 0; n_shift = 0;
    m_cnt0 = 0; m_cnt1 = 0;
  endtask

  task automatic release_reset();
    repeat (2) step();
    @(posedge Clk);
    #2;
    Reset_n = 1'b1;
  endtask

  task automatic wait_idle(input int max);
    int n = 0;
    do begin
      step();
      n++;
    end while (!(q0.size() == 0 && q1.size() == 0 && exp_q.size() == 0) && n < max);
    if (n >= max) check("idle_timeout", exp_q.size() + q0.size() + q1.size(), 0);
  endtask

  task automatic check_cnts();
`ifdef MULT_ARB_STATS_EN
    check("cnt0", cnt0, m_cnt0 & 16'hFFFF);
    check("cnt1", cnt1, m_cnt1 & 16'hFFFF);
`else
    check("cnt0_tied", cnt0, 0);
    check("cnt1_tied", cnt1, 0);
`endif
  endtask

  initial begin
    int  k;
    op_t op;
    Reset_n    = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
    rsp_ready  = 1'b1;
    #1;
    check_all_zero();
    release_reset();

    // Basic products and latencies, including the most negative corner.
    q0.push_back('{8'h07, 8'h03});
    wait_idle(100);
    q1.push_back('{8'hF9, 8'h03});
    q1.push_back('{8'h07, 8'hFD});
    q1.push_back('{8'h80, 8'h80});
    wait_idle(200);
    check_cnts();

    // Both requesters valid continuously from reset: grants alternate.
    assert_reset();
    for (int i = 0; i < 3; i++) q0.push_back('{BITS'($urandom), BITS'($urandom)});
    for (int i = 0; i < 2; i++) q1.push_back('{BITS'($urandom), BITS'($urandom)});
    release_reset();
    wait_idle(300);
    check("grant_count", grant_log.size(), 5);
    for (int i = 0; i < 5 && i < grant_log.size(); i++) check("rr_order", grant_log[i], i % 2);
    check_cnts();

    // Consumer stall in DONE with both requesters waiting.
    rdy_mode = 2;
    q0.push_back('{8'h35, 8'h0B});
    k = 0;
    while (!rsp_valid && k < 60) begin step(); k++; end
    check("stall_reach_done", rsp_valid, 1);
    q0.push_back('{8'h11, 8'h22});
    q1.push_back('{8'hEE, 8'h33});
    repeat (5) begin
      step();
      check("stall_valid", rsp_valid, 1);
    end
    rdy_mode = 0;
    wait_idle(200);

    // Reset in the middle of a SHIFT sequence discards the product.
    q0.push_back('{8'h05, 8'h00});
    k = 0;
    while (!acc0 && k < 20) begin step(); k++; end
    check("mid_accept", acc0, 1);
    repeat (3) step();
    check("in_shift", shift_en, 1);
    assert_reset();
    q1.push_back('{8'h7F, 8'h81});
    release_reset();
    wait_idle(100);
    repeat (20) step();
    q0.push_back('{8'h13, 8'hA5});
    wait_idle(100);
    check_cnts();

    // Randomized traffic with a stuttering consumer.
    rdy_mode = 1;
    for (int i = 0; i < 40; i++) begin
      op.a = BITS'($urandom);
      op.b = BITS'($urandom);
      if ($urandom_range(0, 7) == 0) op = '{8'h80, 8'h80};
      if ($urandom_range(0, 1) == 1) q1.push_back(op); else q0.push_back(op);
      repeat ($urandom_range(0, 12)) step();
    end
    wait_idle(3000);
    rdy_mode = 0;
    check_cnts();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule
